// File: rtl/cipher_round_ctrl_pkg.sv
// Shared types and constants for the AES-128 round controller.
// State enum, round count, key index type and round-constant table.
package cipher_round_ctrl_pkg;

  localparam int NR = 10;

  typedef logic [3:0] idx_t;

  typedef enum logic [2:0] {
    IDLE,
    KEYGEN,
    ARK,
    ROUND,
    OUT
  } state_t;

  localparam logic [7:0] RCON [0:NR] = '{
    8'h00, 8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] rcon_at(
    input idx_t i
  );
    if (i <= idx_t'(NR)) return RCON[i];
    return 8'h00;
  endfunction

endpackage

// File: rtl/cipher_round_ctrl_if.sv
// Handshake and datapath-control bundle of the round controller.
// master = controller side, slave = upstream/downstream/datapath side.
interface cipher_round_ctrl_if;
  import cipher_round_ctrl_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic       key_new;
  logic       key_we;
  idx_t       key_sel;
  logic       ld_key;
  logic [7:0] rcon;
  idx_t       rnd_sel;
  logic       ld_state;
  logic       rnd_en;
  logic       final_rnd;
  logic       out_valid;
  logic       out_ready;

  modport master (
    input  in_valid, key_new, out_ready,
    output in_ready, key_we, key_sel,
    output ld_key, rcon, rnd_sel,
    output ld_state, rnd_en, final_rnd,
    output out_valid
  );

  modport slave (
    output in_valid, key_new, out_ready,
    input  in_ready, key_we, key_sel,
    input  ld_key, rcon, rnd_sel,
    input  ld_state, rnd_en, final_rnd,
    input  out_valid
  );

endinterface

// File: rtl/cipher_round_ctrl_cnt.sv
// Key/round index counter shared by the KEYGEN and ROUND phases.
// Load, increment and terminal-count (index == NR) detect.
module cipher_round_ctrl_cnt
  import cipher_round_ctrl_pkg::*;
#(
  parameter int NR = cipher_round_ctrl_pkg::NR
) (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  idx_t ld_val,
  input  logic inc,
  output idx_t cnt,
  output logic tc
);

  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (ld)  cnt <= ld_val;
    else if (inc) cnt <= cnt + idx_t'(1);
  end

  assign tc = (cnt == idx_t'(NR));

endmodule

// File: rtl/cipher_round_ctrl.sv
// AES-128 round controller: key expansion sequencing, initial
// AddRoundKey, NR cipher rounds and output hold.
module cipher_round_ctrl
  import cipher_round_ctrl_pkg::*;
#(
  parameter int NR = cipher_round_ctrl_pkg::NR
) (
  input  logic                  clk,
  input  logic                  rst,
  cipher_round_ctrl_if.master   bus
);

  state_t state;
  state_t nxt;
  logic   keys_valid;
  logic   kv_set;
  logic   cnt_ld;
  idx_t   cnt_val;
  logic   cnt_inc;
  idx_t   cnt;
  logic   tc;
  logic   run;

  cipher_round_ctrl_cnt #(
    .NR (NR)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .ld     (cnt_ld),
    .ld_val (cnt_val),
    .inc    (cnt_inc),
    .cnt    (cnt),
    .tc     (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)         keys_valid <= 1'b0;
    else if (kv_set) keys_valid <= 1'b1;
  end

  always_comb begin
    nxt     = state;
    kv_set  = 1'b0;
    cnt_ld  = 1'b0;
    cnt_val = '0;
    cnt_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          cnt_ld = 1'b1;
          if (bus.key_new || !keys_valid)
            nxt = KEYGEN;
          else
            nxt = ARK;
        end
      end
      KEYGEN: begin
        if (tc) begin
          kv_set = 1'b1;
          nxt    = ARK;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ARK: begin
        // rounds index round keys 1..NR
        cnt_ld  = 1'b1;
        cnt_val = idx_t'(1);
        nxt     = ROUND;
      end
      ROUND: begin
        if (tc) nxt = OUT;
        else    cnt_inc = 1'b1;
      end
      OUT: begin
        if (bus.out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // every output is forced low while reset is held
  assign run = !rst;

  assign bus.in_ready  = run && (state == IDLE);
  assign bus.key_we    = run && (state == KEYGEN);
  assign bus.key_sel   = bus.key_we ? cnt : '0;
  assign bus.ld_key    = bus.key_we && (cnt == '0);
  assign bus.rcon      = bus.key_we ? rcon_at(cnt) : '0;
  assign bus.ld_state  = run && (state == ARK);
  assign bus.rnd_en    = run && (state == ROUND);
  assign bus.rnd_sel   = bus.rnd_en ? cnt : '0;
  assign bus.final_rnd = bus.rnd_en && tc;
  assign bus.out_valid = run && (state == OUT);

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// Scoreboard bench for cipher_round_ctrl: requests push the
// expected per-cycle control trace, a negedge monitor checks it.
module tb_cipher_round_ctrl;

  typedef struct packed {
    logic       in_ready;
    logic       key_we;
    logic [3:0] key_sel;
    logic       ld_key;
    logic [7:0] rcon;
    logic [3:0] rnd_sel;
    logic       ld_state;
    logic       rnd_en;
    logic       final_rnd;
    logic       out_valid;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  logic clk;
  logic rst;
  cipher_round_ctrl_if bus ();

  cipher_round_ctrl #(
    .NR (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  bit   kv_model = 1'b0;
  obs_t a;
  exp_t e;

  function automatic logic [7:0] rcon_ref(input int k);
    logic [7:0] r;
    if (k == 0) return 8'h00;
    r = 8'h01;
    for (int i = 1; i < k; i++)
      r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s.in_ready  = bus.in_ready;
    s.key_we    = bus.key_we;
    s.key_sel   = bus.key_sel;
    s.ld_key    = bus.ld_key;
    s.rcon      = bus.rcon;
    s.rnd_sel   = bus.rnd_sel;
    s.ld_state  = bus.ld_state;
    s.rnd_en    = bus.rnd_en;
    s.final_rnd = bus.final_rnd;
    s.out_valid = bus.out_valid;
    return s;
  endfunction

  function automatic bit active(input obs_t s);
    obs_t m;
    m = s;
    m.in_ready = 1'b0;
    return m != '0;
  endfunction

  function automatic obs_t idle_obs();
    obs_t m;
    m = '0;
    m.in_ready = 1'b1;
    return m;
  endfunction

  always @(negedge clk) begin
    a = sample();
    cyc++;
    nvec++;
    if (a.key_sel > 4'd10 || a.rnd_sel > 4'd10 ||
        $countones({a.key_we, a.ld_state, a.rnd_en}) > 1) begin
      nerr++;
      $display("FAIL range_excl t=%0t got=%h", $time, a);
    end
    if (rst) begin
      q.delete();
      nvec++;
      if (a !== '0) begin
        nerr++;
        $display("FAIL rst_out t=%0t got=%h exp=0", $time, a);
      end
    end else if (active(a)) begin
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL spurious t=%0t got=%h exp=idle", $time, a);
      end else begin
        e = q.pop_front();
        if (a !== e.o || cyc != e.cyc) begin
          nerr++;
          $display("FAIL trace t=%0t cyc=%0d got=%h exp cyc=%0d %h",
                   $time, cyc, a, e.cyc, e.o);
        end
      end
    end else begin
      nvec++;
      if (a !== idle_obs()) begin
        nerr++;
        $display("FAIL idle t=%0t got=%h exp=%h",
                 $time, a, idle_obs());
      end
      if (q.size() != 0) begin
        if (bus.in_valid) begin
          cyc = 0;
        end else begin
          nvec++;
          nerr++;
          $display("FAIL stall t=%0t cyc=%0d exp cyc=%0d",
                   $time, cyc, q[0].cyc);
          q.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    kv_model = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      bus.out_ready = 1'($urandom);
      bus.key_new   = 1'($urandom);
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic req(input bit kn, input int hold,
                     input int abort_at);
    bit   gen;
    int   lat;
    int   c;
    obs_t o;
    gen = kn || !kv_model;
    lat = gen ? 23 : 12;
    c = 1;
    if (gen) begin
      for (int k = 0; k <= 10; k++) begin
        o = '0;
        o.key_we  = 1'b1;
        o.key_sel = 4'(k);
        o.ld_key  = (k == 0);
        o.rcon    = rcon_ref(k);
        q.push_back('{cyc: c, o: o});
        c++;
      end
    end
    o = '0;
    o.ld_state = 1'b1;
    q.push_back('{cyc: c, o: o});
    c++;
    for (int r = 1; r <= 10; r++) begin
      o = '0;
      o.rnd_en    = 1'b1;
      o.rnd_sel   = 4'(r);
      o.final_rnd = (r == 10);
      q.push_back('{cyc: c, o: o});
      c++;
    end
    for (int h = 0; h <= hold; h++) begin
      o = '0;
      o.out_valid = 1'b1;
      q.push_back('{cyc: c, o: o});
      c++;
    end
    bus.in_valid = 1'b1;
    bus.key_new  = kn;
    tick();
    bus.in_valid = 1'b0;
    for (int n = 1; n < lat + hold; n++) begin
      if (n == abort_at) begin
        do_reset(2);
        return;
      end
      bus.key_new   = 1'($urandom);
      bus.in_valid  = 1'($urandom);
      bus.out_ready = (n < lat) ? 1'($urandom) : 1'b0;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    kv_model = 1'b1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.key_new   = 1'b0;
    bus.out_ready = 1'b0;
    do_reset(3);
    idle(2);
    req(1'b1, 0, 0);
    idle(2);
    req(1'b0, 0, 0);
    req(1'b0, 5, 0);
    idle(1);
    req(1'b1, 0, 7);
    idle(1);
    req(1'b0, 0, 0);
    do_reset(2);
    req(1'b0, 2, 0);
    req(1'b0, 0, 5);
    req(1'b0, 1, 0);
    for (int i = 0; i < 24; i++) begin
      idle($urandom_range(0, 3));
      req(1'($urandom), $urandom_range(0, 5),
          ($urandom_range(0, 5) == 0) ? $urandom_range(1, 22) : 0);
    end
    idle(4);
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cipher_round_ctrl.md
CIPHER_ROUND_CTRL -- requirements
Module: cipher_round_ctrl

Interface
REQ-001 Parameter NR, default 10, number of cipher rounds; only 10 (AES-128) is supported, so key indices run 0..NR.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream block/key available.
REQ-005 in_ready  output  1  controller idle and accepting.
REQ-006 key_new  input  1  sampled at input handshake; 1 = expand the supplied key, 0 = reuse the stored round keys.
REQ-007 key_we  output  1  round-key write strobe; drives the 1-to-11 demux data input.
REQ-008 key_sel  output  4  round-key index 0..10; drives the demux select.
REQ-009 ld_key  output  1  load the input key into the expander; asserted only with key_sel=0.
REQ-010 rcon  output  8  round constant for the expander step at index key_sel.
REQ-011 rnd_sel  output  4  round-key read index for the datapath.
REQ-012 ld_state  output  1  load plaintext and apply the initial AddRoundKey.
REQ-013 rnd_en  output  1  datapath round enable.
REQ-014 final_rnd  output  1  current round skips MixColumns.
REQ-015 out_valid  output  1  ciphertext valid.
REQ-016 out_ready  input  1  downstream accepts the ciphertext.

Function
REQ-017 FSM states are IDLE, KEYGEN, ARK, ROUND and OUT; the encoding is a free choice.
REQ-018 in_ready SHALL be 1 only in IDLE; the input handshake is in_valid&in_ready on a rising edge.
- Cycle numbering: cycle n = n cycles after the input handshake edge.
REQ-019 On handshake, the FSM SHALL go to KEYGEN if key_new=1 or keys_valid=0; otherwise it SHALL go to ARK.
REQ-020 KEYGEN lasts 11 cycles with key_we=1 and key_sel=0,1,...,10 on successive cycles.
- ld_key=1 only at key_sel=0.
REQ-021 rcon SHALL be 00 at key_sel=0 and 01,02,04,08,10,20,40,80,1B,36 at key_sel=1..10; rcon SHALL be 00 outside KEYGEN.
REQ-022 After key_sel=10, keys_valid (internal flag) SHALL set and the FSM SHALL go to ARK.
REQ-023 ARK lasts 1 cycle with ld_state=1 and rnd_sel=0.
REQ-024 ROUND lasts 10 cycles with rnd_en=1 and rnd_sel=1..10.
- final_rnd=1 only when rnd_sel=10.
REQ-025 OUT SHALL hold out_valid=1 until out_ready=1; on that edge the FSM SHALL return to IDLE.
- out_ready=1 on the first OUT cycle gives a 1-cycle out_valid pulse.
REQ-026 Latency SHALL be: first out_valid at cycle 23 with KEYGEN; at cycle 12 when keys are reused.
REQ-027 In every state other than its own phase, each strobe and index output SHALL be 0.
REQ-028 in_valid SHALL be ignored outside IDLE; key_new SHALL only be sampled at the handshake.
REQ-029 out_ready outside OUT SHALL have no effect.
REQ-030 key_sel and rnd_sel SHALL never exceed 10; codes 11..15 are never driven.

Reset
REQ-031 rst=1 on any edge SHALL force IDLE, including mid-KEYGEN or mid-ROUND.
REQ-032 rst SHALL clear keys_valid and the counter.
- All outputs SHALL be 0 except in_ready.
- in_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst drops.
REQ-033 A reset during KEYGEN SHALL leave keys_valid=0, so the next request SHALL regenerate keys regardless of key_new.

Structure
REQ-034 A shared package SHALL hold the state enum, the NR constant, the 4-bit index type and the 11-entry RCON constant table.
REQ-035 One 4-bit index counter SHALL be shared by KEYGEN and ROUND, with load, increment and terminal-count detect.
REQ-036 No sub-module is required; the 1-to-11 demux is instantiated by the parent, not inside this block.

Verification
REQ-037 Reset then key_new=1 request -> key_we high for cycles 1-11 with key_sel 0..10 and rcon 00,01,...,36; ld_state at cycle 12; rnd_en for cycles 13-22; final_rnd at cycle 22; out_valid at cycle 23.
REQ-038 Second request with key_new=0 and out_ready held 1 -> no key_we; ld_state at cycle 1; out_valid pulse of exactly 1 cycle at cycle 12.
REQ-039 out_ready held 0 for 5 cycles in OUT -> out_valid stays 1 and in_ready stays 0 throughout; in_valid during that window is ignored.
REQ-040 rst asserted at key_sel=6, then a key_new=0 request -> full KEYGEN occurs (key_sel 0..10) because keys_valid was cleared.
REQ-041 First request after reset with key_new=0 -> KEYGEN still runs; out_valid at cycle 23.
REQ-042 Over all runs, assert key_sel<=10 and rnd_sel<=10.
- Assert key_we, ld_state and rnd_en are mutually exclusive.
